// File: rtl/div_unit_if.sv
// Handshake bundle between the EX stage and the iterative divider.
// The pipeline side drives operands and start; the divider returns stall, busy and the result.
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             stall;
    logic             busy;
    logic [WIDTH-1:0] result;
    logic             result_valid;

    modport master (
        output start, funct3, op_a, op_b,
        input  stall, busy, result, result_valid
    );

    modport slave (
        input  start, funct3, op_a, op_b,
        output stall, busy, result, result_valid
    );
endinterface

// File: rtl/div_unit.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Divide-by-zero and signed overflow bypass the iteration and finish in one cycle.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    div_unit_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ALL_ONE = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return (~v) + ONE;
    endfunction

    state_t           state_r;
    logic [5:0]       count_r;
    logic [2:0]       funct3_r;
    logic [WIDTH-1:0] divisor_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH:0]   rem_r;
    logic [WIDTH-1:0] result_r;
    logic             q_neg_r;
    logic             r_neg_r;
    logic             busy_r;
    logic             valid_r;

    logic             is_signed_s;
    logic             div_zero_s;
    logic             overflow_s;
    logic [WIDTH-1:0] a_mag_s;
    logic [WIDTH-1:0] b_mag_s;
    logic [WIDTH-1:0] fast_result_s;
    logic [WIDTH:0]   rem_shift_s;
    logic             q_bit_s;
    logic [WIDTH:0]   rem_next_s;
    logic [WIDTH-1:0] quo_next_s;
    logic [WIDTH-1:0] final_result_s;
    logic             stall_s;
    logic [1:0]       spare_unused_s;

    // Rem_r's top bit is always clear after a subtraction; funct3 bit 2 is common to all four ops
    assign spare_unused_s = {rem_r[WIDTH], funct3_r[2]};

    // Decode the incoming operation: magnitudes, special cases and the fast-path answer
    always_comb begin
        is_signed_s   = ~bus.funct3[0];
        div_zero_s    = (bus.op_b == ZERO);
        overflow_s    = is_signed_s && (bus.op_a == MIN_NEG) && (bus.op_b == ALL_ONE);
        a_mag_s       = bus.op_a;
        b_mag_s       = bus.op_b;
        fast_result_s = ZERO;
        if (is_signed_s && bus.op_a[WIDTH-1]) begin
            a_mag_s = negate(bus.op_a);
        end else begin
            a_mag_s = bus.op_a;
        end
        if (is_signed_s && bus.op_b[WIDTH-1]) begin
            b_mag_s = negate(bus.op_b);
        end else begin
            b_mag_s = bus.op_b;
        end
        if (div_zero_s) begin
            fast_result_s = bus.funct3[1] ? bus.op_a : ALL_ONE;
        end else begin
            fast_result_s = bus.funct3[1] ? ZERO : MIN_NEG;
        end
    end

    // One restoring step: shift in the next dividend bit and subtract if it fits
    always_comb begin
        rem_shift_s    = {rem_r[WIDTH-1:0], quo_r[WIDTH-1]};
        q_bit_s        = (rem_shift_s >= {1'b0, divisor_r});
        rem_next_s     = rem_shift_s;
        quo_next_s     = {quo_r[WIDTH-2:0], q_bit_s};
        final_result_s = ZERO;
        if (q_bit_s) begin
            rem_next_s = rem_shift_s - {1'b0, divisor_r};
        end else begin
            rem_next_s = rem_shift_s;
        end
        if (funct3_r[1]) begin
            final_result_s = r_neg_r ? negate(rem_next_s[WIDTH-1:0]) : rem_next_s[WIDTH-1:0];
        end else begin
            final_result_s = q_neg_r ? negate(quo_next_s) : quo_next_s;
        end
    end

    // Freeze request: the accepting cycle plus every iteration, never while in reset
    assign stall_s = ~rst && (((state_r == IDLE) && bus.start) || (state_r == BUSY));

    assign bus.stall        = stall_s;
    assign bus.busy         = busy_r;
    assign bus.result       = result_r;
    assign bus.result_valid = valid_r;

    // Control FSM with datapath registers and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            count_r   <= 6'd0;
            funct3_r  <= 3'd0;
            divisor_r <= ZERO;
            quo_r     <= ZERO;
            rem_r     <= {(WIDTH+1){1'b0}};
            result_r  <= ZERO;
            q_neg_r   <= 1'b0;
            r_neg_r   <= 1'b0;
            busy_r    <= 1'b0;
            valid_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                    if (bus.start) begin
                        funct3_r  <= bus.funct3;
                        divisor_r <= b_mag_s;
                        quo_r     <= a_mag_s;
                        rem_r     <= {(WIDTH+1){1'b0}};
                        count_r   <= 6'd0;
                        q_neg_r   <= is_signed_s && (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
                        r_neg_r   <= is_signed_s && bus.op_a[WIDTH-1];
                        if (div_zero_s || overflow_s) begin
                            result_r <= fast_result_s;
                            valid_r  <= 1'b1;
                            state_r  <= DONE;
                        end else begin
                            busy_r  <= 1'b1;
                            state_r <= BUSY;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    rem_r <= rem_next_s;
                    quo_r <= quo_next_s;
                    if (count_r == 6'(WIDTH - 1)) begin
                        result_r <= final_result_s;
                        count_r  <= 6'd0;
                        busy_r   <= 1'b0;
                        valid_r  <= 1'b1;
                        state_r  <= DONE;
                    end else begin
                        count_r <= count_r + 6'd1;
                        state_r <= BUSY;
                    end
                end
                DONE: begin
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                    count_r <= 6'd0;
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected results are queued at issue and compared at result_valid.
module tb_div_unit;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [31:0] sb_q[$];

    div_unit_if #(.WIDTH(32)) bus ();

    div_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } op_t;

    localparam logic [2:0] F_DIV  = 3'b100;
    localparam logic [2:0] F_DIVU = 3'b101;
    localparam logic [2:0] F_REM  = 3'b110;
    localparam logic [2:0] F_REMU = 3'b111;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3[1:0])
            2'b00:   return (b == 32'd0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b)));
            2'b01:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            2'b10:   return (b == 32'd0) ? a : (ovf ? 32'd0 : 32'($signed(a) % $signed(b)));
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_fast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!f3[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
    endfunction

    // Issue one op in the cycle after the previous DONE; start stays high through DONE
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int stalls;
        bit seen;
        logic [31:0] e;
        @(posedge clk);
        #1;
        bus.start  = 1'b1;
        bus.funct3 = f3;
        bus.op_a   = a;
        bus.op_b   = b;
        sb_q.push_back(exp);
        stalls = 0;
        seen   = 1'b0;
        @(negedge clk);
        check_value({tag, "_idle_busy"}, {31'd0, bus.busy}, 32'd0);
        check_value({tag, "_idle_valid"}, {31'd0, bus.result_valid}, 32'd0);
        for (int c = 0; c < 60 && !seen; c++) begin
            if (c > 0) @(negedge clk);
            if (bus.result_valid) begin
                seen = 1'b1;
                check_value({tag, "_done_stall"}, {31'd0, bus.stall}, 32'd0);
            end else if (bus.stall) begin
                stalls++;
            end
            if (c == 1) begin
                bus.op_a = $urandom;
                bus.op_b = $urandom;
            end
        end
        e = sb_q.pop_front();
        if (seen) begin
            check_value({tag, "_result"}, bus.result, e);
            check_value({tag, "_stalls"}, 32'(stalls), is_fast(f3, a, b) ? 32'd1 : 32'd33);
        end else begin
            check_value({tag, "_timeout"}, 32'd0, 32'd1);
        end
    endtask

    op_t plan[13];

    initial begin
        logic [2:0]  rf3;
        logic [31:0] ra;
        logic [31:0] rb;
        int          vcount;
        total = 0;
        bad   = 0;
        plan[0]  = '{F_DIVU, 32'd100,        32'd7,          32'd14};
        plan[1]  = '{F_REMU, 32'd100,        32'd7,          32'd2};
        plan[2]  = '{F_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
        plan[3]  = '{F_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
        plan[4]  = '{F_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD};
        plan[5]  = '{F_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF};
        plan[6]  = '{F_DIV,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF};
        plan[7]  = '{F_REM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB};
        plan[8]  = '{F_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
        plan[9]  = '{F_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
        plan[10] = '{F_DIVU, 32'd9,          32'd3,          32'd3};
        plan[11] = '{F_REMU, 32'hFFFF_FFFF,  32'd1,          32'd0};
        plan[12] = '{F_REM,  32'h8000_0000,  32'd3,          32'hFFFF_FFFE};

        // Reset with start high: stall must still read 0
        rst        = 1'b1;
        bus.start  = 1'b1;
        bus.funct3 = F_DIVU;
        bus.op_a   = 32'd100;
        bus.op_b   = 32'd7;
        @(posedge clk);
        @(negedge clk);
        check_value("rst_stall", {31'd0, bus.stall}, 32'd0);
        check_value("rst_busy", {31'd0, bus.busy}, 32'd0);
        check_value("rst_result", bus.result, 32'd0);
        check_value("rst_valid", {31'd0, bus.result_valid}, 32'd0);
        bus.start = 1'b0;
        rst       = 1'b0;

        foreach (plan[i]) begin
            run_op($sformatf("plan%0d", i), plan[i].f3, plan[i].a, plan[i].b, plan[i].exp);
        end
        for (int i = 0; i < 8; i++) begin
            rf3 = F_DIV + 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            if (i % 3 == 0) rb = -rb;
            run_op($sformatf("rnd%0d", i), rf3, ra, rb, model(rf3, ra, rb));
        end

        // Result holds with start low in IDLE
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_value("hold_result", bus.result, model(rf3, ra, rb));
        check_value("hold_stall", {31'd0, bus.stall}, 32'd0);

        // Reset during BUSY iteration 10 discards the division
        @(posedge clk);
        #1;
        bus.start  = 1'b1;
        bus.funct3 = F_DIVU;
        bus.op_a   = 32'hFFFF_FFFF;
        bus.op_b   = 32'd3;
        repeat (11) @(posedge clk);
        #1;
        @(negedge clk);
        check_value("mid_busy", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        #1;
        check_value("mid_rst_stall", {31'd0, bus.stall}, 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check_value("post_rst_stall", {31'd0, bus.stall}, 32'd0);
        check_value("post_rst_busy", {31'd0, bus.busy}, 32'd0);
        check_value("post_rst_result", bus.result, 32'd0);
        vcount = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.result_valid) vcount++;
            @(negedge clk);
        end
        check_value("post_rst_no_valid", 32'(vcount), 32'd0);
        run_op("fresh", F_DIVU, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555);

        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        check_value("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-bit divider for the RV32M DIV/DIVU/REM/REMU instructions. It sits in the EX stage beside the ALU. It generates the `stall` request that the hazard logic uses to freeze PC, IF/ID and ID/EX while a division is in flight. On the release cycle it returns the quotient or remainder to the EX result mux.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width. Only 32 is verified.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `start` input 1: a DIV/DIVU/REM/REMU is valid in EX. Held high by the frozen ID/EX register until the pipeline advances.
- `funct3` input 3: `100` DIV, `101` DIVU, `110` REM, `111` REMU. Sampled only when an operation is accepted.
- `op_a` input WIDTH: dividend, forwarded rs1 value.
- `op_b` input WIDTH: divisor, forwarded rs2 value.
- `stall` output 1: pipeline-freeze request to the hazard unit.
- `busy` output 1: high in BUSY.
- `result` output WIDTH: quotient or remainder. Registered.
- `result_valid` output 1: high in DONE only.

## Operation
- State machine with three states: IDLE, BUSY, DONE. Reset state is IDLE.
- `stall` is combinational: `(IDLE & start) | BUSY`. It is forced to 0 while `rst` is high.
- IDLE with `start` = 1 accepts the operation:
  - Latch `funct3`.
  - Latch the operand magnitudes: two's-complement absolute value for DIV/REM, raw value for DIVU/REMU.
  - Latch the quotient sign (`a[31]^b[31]`, signed ops only) and the remainder sign (`a[31]`, signed ops only).
- Fast path, IDLE → DONE, no iterations:
  - Divisor zero: quotient = 0xFFFFFFFF for both signed and unsigned; remainder = `op_a` unchanged.
  - Signed overflow (`op_a`=0x80000000, `op_b`=0xFFFFFFFF, DIV/REM): quotient = 0x80000000, remainder = 0.
- Normal path, IDLE → BUSY:
  - Restoring division over a 6-bit iteration counter, 0..31, one quotient bit per cycle, MSB first.
  - Partial remainder is WIDTH+1 bits wide.
  - When the counter reaches 31, the next state is DONE.
- Entering DONE loads `result`:
  - DIV/DIVU load the quotient; REM/REMU load the remainder.
  - The value is negated when the latched sign flag is set. This correction does not apply to fast-path results, which are loaded verbatim.
- DONE:
  - `result_valid` = 1 and `stall` = 0, so the pipeline advances this cycle.
  - Unconditional return to IDLE; `start` is ignored in DONE.
  - `result` holds its value until the next accepted operation.
- `start` low in IDLE: no state change, `result` holds.
- `rst` in any state, including mid-BUSY:
  - Next cycle: IDLE, counter 0, `result` 0, `result_valid` 0, `busy` 0.
  - In-flight operation is discarded; no partial result is exposed.

## Timing
- Reset values: `stall` 0, `busy` 0, `result` 0x00000000, `result_valid` 0.
- Normal op, `start` seen at cycle 0:
  - `stall` high cycles 0–32 (33 cycles).
  - BUSY cycles 1–32.
  - DONE at cycle 33: `result` valid, `stall` 0.
- Fast path: `stall` high at cycle 0 only; DONE at cycle 1.
- Back-to-back divisions: the pipeline advances at DONE, so IDLE is entered with the next instruction in EX. A second `start` is accepted one cycle after DONE, giving minimum spacing of 34 cycles (normal) or 2 cycles (fast path).
- Operands are not sampled after acceptance; forwarding changes during BUSY have no effect.

## Test plan
- DIVU 100/7: `stall` high exactly 33 cycles → `result`=14, `result_valid` one cycle. Same operands with REMU → 2.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD (−3). REM → 0xFFFFFFFF (−1). DIV 7/0xFFFFFFFE → 0xFFFFFFFD.
- Divide by zero:
  - DIVU 5/0 → 0xFFFFFFFF.
  - DIV −5/0 → 0xFFFFFFFF.
  - REM 0xFFFFFFFB/0 → 0xFFFFFFFB.
  - Each has `stall` high for 1 cycle only.
- Overflow DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0; 1 stall cycle.
- `start` held high through DONE → no restart, IDLE next cycle. Re-asserted DIVU 9/3 one cycle after DONE → accepted, result 3 after 33 stall cycles.
- `rst` pulsed at BUSY iteration 10 of DIVU 0xFFFFFFFF/3 → next cycle IDLE, `stall` 0, `result` 0, `result_valid` never asserted. A fresh DIVU 0xFFFFFFFF/3 afterwards returns 0x55555555.
